// File: rtl/wb_regfile_if.sv
// MEM/WB writeback and decode read-port bundle for wb_regfile.
// The master drives pipeline/read indices; the slave (register file) returns data.
interface wb_regfile_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic [DATA_W-1:0] mem_address_in;
    logic [DATA_W-1:0] mem_data_in;
    logic [ADDR_W-1:0] write_reg_in;
    logic              regWrite_in;
    logic              mem2Reg_in;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [CNT_W-1:0]  write_count;

    modport master (
        output mem_address_in, mem_data_in, write_reg_in, regWrite_in, mem2Reg_in,
        output read_reg1, read_reg2,
        input  read_data1, read_data2, wb_data, wb_valid, write_count
    );

    modport slave (
        input  mem_address_in, mem_data_in, write_reg_in, regWrite_in, mem2Reg_in,
        input  read_reg1, read_reg2,
        output read_data1, read_data2, wb_data, wb_valid, write_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage plus LEGv8 integer register file: writeback mux, one commit per edge,
// two combinational read ports with same-cycle bypass, XZR reads zero, saturating commit count.
module wb_regfile_cell #(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)  r_q <= '0;
        else if (i_we) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

module wb_regfile #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic          CLK,
    input  logic          RESET_N,
    wb_regfile_if.slave   bus
);
    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_valid;
    logic [DATA_W-1:0] w_regs [NREGS];
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_wb_data  = bus.mem2Reg_in ? bus.mem_data_in : bus.mem_address_in;
    // Gated by reset so a write pending when reset hits never reaches storage or the bypass.
    assign w_wb_valid = RESET_N && bus.regWrite_in && (bus.write_reg_in != ZIDX);

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        if (g == ZERO_REG) begin : g_zero
            assign w_regs[g] = '0;
        end else begin : g_cell
            logic w_we;
            assign w_we = w_wb_valid && (bus.write_reg_in == ADDR_W'(g));
            wb_regfile_cell #(.DATA_W(DATA_W)) u_cell (
                .CLK     (CLK),
                .RESET_N (RESET_N),
                .i_we    (w_we),
                .i_d     (w_wb_data),
                .o_q     (w_regs[g])
            );
        end
    end

    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] idx);
        if (idx == ZIDX)                                 return '0;
        else if (w_wb_valid && idx == bus.write_reg_in)  return w_wb_data;
        else                                             return w_regs[idx];
    endfunction

    always_comb begin
        w_rd1 = f_read(bus.read_reg1);
        w_rd2 = f_read(bus.read_reg2);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_count <= '0;
        else if (w_wb_valid && r_count != {CNT_W{1'b1}})
            r_count <= r_count + CNT_W'(1);
    end

    assign bus.read_data1  = w_rd1;
    assign bus.read_data2  = w_rd2;
    assign bus.wb_data     = w_wb_data;
    assign bus.wb_valid    = w_wb_valid;
    assign bus.write_count = r_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus randomized bench for wb_regfile against an array-based register model.
module tb_wb_regfile;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    wb_regfile_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(2))  bus2 ();

    wb_regfile #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .CNT_W(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus));
    wb_regfile #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .CNT_W(2)) dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus2));

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    logic [63:0] model [32];
    longint cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [63:0] addr,
                         input logic [63:0] data, input logic [4:0] wr,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.regWrite_in    = rw;
        bus.mem2Reg_in     = m2r;
        bus.mem_address_in = addr;
        bus.mem_data_in    = data;
        bus.write_reg_in   = wr;
        bus.read_reg1      = r1;
        bus.read_reg2      = r2;
    endtask

    function automatic logic [63:0] exp_wb();
        return bus.mem2Reg_in ? bus.mem_data_in : bus.mem_address_in;
    endfunction

    function automatic logic exp_valid();
        return RESET_N && bus.regWrite_in && (bus.write_reg_in != 5'd31);
    endfunction

    function automatic logic [63:0] exp_rd(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
        if (exp_valid() && idx == bus.write_reg_in) return exp_wb();
        return model[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        cnt = 0;
    endtask

    // Advance one edge, applying the architectural effect of the pending writeback to the model.
    task automatic step();
        logic        v;
        logic [63:0] w;
        logic [4:0]  d;
        v = exp_valid(); w = exp_wb(); d = bus.write_reg_in;
        @(posedge CLK);
        if (v) begin
            model[d] = w;
            if (cnt < 64'hFFFF_FFFF) cnt++;
        end
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    initial begin
        logic [63:0] v9, v10, ra, rd;
        logic [4:0]  rw_i, r1, r2;
        model_reset();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd1);
        bus2.regWrite_in = 1'b0; bus2.mem2Reg_in = 1'b0; bus2.mem_address_in = '0;
        bus2.mem_data_in = '0; bus2.write_reg_in = '0; bus2.read_reg1 = '0; bus2.read_reg2 = '0;

        // Reset state
        at_neg(); at_neg();
        chk("reset_rd1", bus.read_data1, 64'd0);
        chk("reset_cnt", 64'(bus.write_count), 64'd0);
        RESET_N = 1'b1;

        // ALU writeback to X3
        at_neg();
        drive(1'b1, 1'b0, 64'hDEADBEEF00000001, 64'h1111, 5'd3, 5'd3, 5'd0);
        #1;
        chk("alu_wb_data", bus.wb_data, 64'hDEADBEEF00000001);
        chk("alu_wb_valid", 64'(bus.wb_valid), 64'd1);
        step();
        at_neg();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd3, 5'd3);
        #1;
        chk("alu_x3", bus.read_data1, 64'hDEADBEEF00000001);
        chk("alu_cnt", 64'(bus.write_count), 64'd1);

        // Load writeback to X7 with same-cycle bypass
        at_neg();
        drive(1'b1, 1'b1, 64'h0BAD, 64'h00000000CAFEF00D, 5'd7, 5'd7, 5'd7);
        #1;
        chk("load_bypass1", bus.read_data1, 64'h00000000CAFEF00D);
        chk("load_bypass2", bus.read_data2, 64'h00000000CAFEF00D);
        step();
        bus.regWrite_in = 1'b0;
        #1;
        chk("load_held", bus.read_data1, 64'h00000000CAFEF00D);

        // XZR write is discarded
        at_neg();
        drive(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 5'd31, 5'd31, 5'd31);
        #1;
        chk("xzr_rd1", bus.read_data1, 64'd0);
        chk("xzr_rd2", bus.read_data2, 64'd0);
        chk("xzr_valid", 64'(bus.wb_valid), 64'd0);
        step();
        chk("xzr_cnt", 64'(bus.write_count), 64'd2);

        // Disabled write leaves X4 alone
        at_neg();
        drive(1'b1, 1'b0, 64'h99, 64'd0, 5'd4, 5'd0, 5'd0);
        step();
        at_neg();
        drive(1'b0, 1'b0, 64'h55, 64'd0, 5'd4, 5'd4, 5'd4);
        #1;
        chk("dis_bypass", bus.read_data1, 64'h99);
        chk("dis_valid", 64'(bus.wb_valid), 64'd0);
        step();
        chk("dis_x4", bus.read_data2, 64'h99);
        chk("dis_cnt", 64'(bus.write_count), 64'd3);

        // Back-to-back commits to X9 and X10
        v9  = {$urandom, $urandom};
        v10 = ~v9;
        at_neg();
        drive(1'b1, 1'b0, v9, 64'd0, 5'd9, 5'd0, 5'd0);
        step();
        drive(1'b1, 1'b1, 64'd0, v10, 5'd10, 5'd0, 5'd0);
        step();
        at_neg();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd9, 5'd10);
        #1;
        chk("b2b_x9", bus.read_data1, v9);
        chk("b2b_x10", bus.read_data2, v10);
        chk("b2b_cnt", 64'(bus.write_count), 64'd5);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            at_neg();
            rw_i = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? rw_i : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 7) == 0) ? r1 : 5'($urandom_range(0, 31));
            ra = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rd, rw_i, r1, r2);
            #1;
            chk("rnd_wb_data", bus.wb_data, exp_wb());
            chk("rnd_wb_valid", 64'(bus.wb_valid), 64'(exp_valid()));
            chk("rnd_rd1", bus.read_data1, exp_rd(r1));
            chk("rnd_rd2", bus.read_data2, exp_rd(r2));
            step();
            chk("rnd_cnt", 64'(bus.write_count), 64'(cnt));
        end

        // Mid-run reset clears state without a clock edge
        at_neg();
        drive(1'b1, 1'b0, 64'h1234, 64'd0, 5'd5, 5'd0, 5'd0);
        step();
        at_neg();
        drive(1'b1, 1'b0, 64'hABCD, 64'd0, 5'd6, 5'd5, 5'd6);
        #2;
        RESET_N = 1'b0;
        model_reset();
        bus.regWrite_in = 1'b0;
        #1;
        chk("mid_rst_x5", bus.read_data1, 64'd0);
        chk("mid_rst_cnt", 64'(bus.write_count), 64'd0);
        bus.regWrite_in = 1'b1;
        @(posedge CLK); #1;
        at_neg();
        RESET_N = 1'b1;
        bus.regWrite_in = 1'b0;
        #1;
        chk("mid_rst_abort_x6", bus.read_data2, 64'd0);

        // First edge after release commits normally
        drive(1'b1, 1'b0, 64'h8888, 64'd0, 5'd8, 5'd0, 5'd0);
        step();
        at_neg();
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd8, 5'd5);
        #1;
        chk("rel_x8", bus.read_data1, 64'h8888);
        chk("rel_x5", bus.read_data2, 64'd0);
        chk("rel_cnt", 64'(bus.write_count), 64'(cnt));

        // Saturation with a 2-bit counter
        chk("sat_start", 64'(bus2.write_count), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            at_neg();
            bus2.regWrite_in    = 1'b1;
            bus2.write_reg_in   = 5'(k);
            bus2.mem_address_in = 64'(k * 3);
            @(posedge CLK); #1;
            chk("sat_cnt", 64'(bus2.write_count), 64'((k < 3) ? k : 3));
        end
        at_neg();
        bus2.regWrite_in = 1'b0;
        bus2.read_reg1   = 5'd5;
        #1;
        chk("sat_x5", bus2.read_data1, 64'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
